// File: rtl/chn_fifo_merge_pkg.sv
// Shared definitions for the N-channel FIFO merge stage.
// Holds the burst header magic byte, the arbiter state type and the round-robin search helper.
package chn_fifo_merge_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hC5;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        RD
    } state_t;

    // Returns {found, index} for the first set bit of elig, starting at ptr and wrapping at n.
    // The search runs from the farthest offset to the nearest, so the nearest eligible channel wins.
    function automatic logic [4:0] rr_pick(input logic [15:0] elig, input logic [3:0] ptr,
                                           input int n);
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (elig[idx[3:0]]) begin
                    res = {1'b1, idx[3:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/chn_fifo_merge_sync_fifo.sv
// Per-channel synchronous FIFO.
// It has a synchronous clear and a registered read port, so data appears one cycle after rd_en.
// A write while the FIFO is full and a read while it is empty are both ignored.
module chn_sync_fifo #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  usedw
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               wr_ok;
    logic               rd_ok;

    assign full  = (usedw == (FIFO_AW + 1)'(DEPTH));
    assign empty = (usedw == '0);
    assign wr_ok = wr_en & ~full & ~clr;
    assign rd_ok = rd_en & ~empty & ~clr;

    // Pointer and fill-level bookkeeping; a simultaneous read and write leaves usedw unchanged.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            usedw <= usedw + (FIFO_AW + 1)'(wr_ok) - (FIFO_AW + 1)'(rd_ok);
        end
    end

    // Storage array with a registered read port; it has no reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
        if (rd_ok) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/chn_fifo_merge.sv
// Merges N channel sample streams into the single USB external FIFO write port.
// Each channel has its own FIFO. A round-robin arbiter drains one burst at a time,
// optionally preceded by a header word that carries the channel tag.
module chn_fifo_merge
    import chn_fifo_merge_pkg::*;
#(
    parameter int N_CHN     = 2,
    parameter int DATA_W    = 16,
    parameter int FIFO_AW   = 10,
    parameter int BURST_LEN = 256,
    parameter int HEADER_EN = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rst_all_fifo,
    input  logic                    flush,
    input  logic [N_CHN*DATA_W-1:0] chn_dataout,
    input  logic [N_CHN-1:0]        chn_dataout_en,
    input  logic                    usb_ext_fifo_afull,
    output logic [DATA_W-1:0]       out_to_usb_ext_fifo_din,
    output logic                    out_to_usb_ext_fifo_en,
    output logic [N_CHN-1:0]        chn_overflow,
    output logic [N_CHN-1:0]        chn_fifo_empty,
    output logic                    busy
);

    localparam int              GW       = (N_CHN > 1) ? $clog2(N_CHN) : 1;
    localparam logic [FIFO_AW:0] BURST_W = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [GW-1:0]    LAST_CH = GW'(N_CHN - 1);

    logic               clr;
    logic [N_CHN-1:0]   full_v;
    logic [N_CHN-1:0]   empty_v;
    logic [N_CHN-1:0]   eligible;
    logic [N_CHN-1:0]   rdreq;
    logic [FIFO_AW:0]   usedw_v [N_CHN];
    logic [DATA_W-1:0]  q_v     [N_CHN];

    state_t             state;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      rr_ptr;
    logic [FIFO_AW:0]   remaining;
    logic               rd_pend;
    logic               rd_issue;
    logic [4:0]         pick;
    logic [GW-1:0]      pick_idx;
    logic [FIFO_AW:0]   pick_usedw;
    logic [7:0]         hdr_chn;

    assign clr            = ~reset_n | rst_all_fifo;
    assign chn_fifo_empty = empty_v;
    assign hdr_chn        = 8'(grant);

    for (genvar gi = 0; gi < N_CHN; gi++) begin : g_chn
        chn_sync_fifo #(
            .DATA_W  (DATA_W),
            .FIFO_AW (FIFO_AW)
        ) u_fifo (
            .clk     (clk),
            .clr     (clr),
            .wr_en   (chn_dataout_en[gi]),
            .wr_data (chn_dataout[gi*DATA_W +: DATA_W]),
            .rd_en   (rdreq[gi]),
            .rd_data (q_v[gi]),
            .full    (full_v[gi]),
            .empty   (empty_v[gi]),
            .usedw   (usedw_v[gi])
        );

        assign eligible[gi] = (usedw_v[gi] >= BURST_W) | (flush & ~empty_v[gi]);
        assign rdreq[gi]    = rd_issue & (grant == GW'(gi));
    end

    // Round-robin candidate selection and the per-cycle read-request decision.
    always_comb begin
        pick       = rr_pick(16'(eligible), 4'(rr_ptr), N_CHN);
        pick_idx   = GW'(pick[3:0]);
        pick_usedw = usedw_v[pick_idx];
        rd_issue   = (state == RD) && !usb_ext_fifo_afull && (remaining != '0);
    end

    // Sticky per-channel flag for writes dropped because the channel FIFO was full.
    always_ff @(posedge clk) begin
        if (clr) begin
            chn_overflow <= '0;
        end else begin
            chn_overflow <= chn_overflow | (chn_dataout_en & full_v);
        end
    end

    // Burst arbiter FSM with registered outputs; words already read still go out while afull is high.
    always_ff @(posedge clk) begin
        if (clr) begin
            state                   <= IDLE;
            grant                   <= '0;
            rr_ptr                  <= '0;
            remaining               <= '0;
            rd_pend                 <= 1'b0;
            out_to_usb_ext_fifo_din <= '0;
            out_to_usb_ext_fifo_en  <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            out_to_usb_ext_fifo_en <= 1'b0;
            rd_pend                <= rd_issue;
            if (rd_pend) begin
                out_to_usb_ext_fifo_din <= q_v[grant];
                out_to_usb_ext_fifo_en  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick[4] && !usb_ext_fifo_afull) begin
                        grant     <= pick_idx;
                        remaining <= (pick_usedw >= BURST_W) ? BURST_W : pick_usedw;
                        state     <= (HEADER_EN != 0) ? HDR : RD;
                        busy      <= 1'b1;
                    end
                end
                HDR: begin
                    if (!usb_ext_fifo_afull) begin
                        out_to_usb_ext_fifo_din <= DATA_W'({HDR_MAGIC, hdr_chn});
                        out_to_usb_ext_fifo_en  <= 1'b1;
                        state                   <= RD;
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        remaining <= remaining - (FIFO_AW + 1)'(1);
                    end
                    if ((remaining == '0) && !rd_pend) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chn_fifo_merge.sv
// Self-checking bench for chn_fifo_merge. It runs directed cases first, then randomized fill and drain rounds.
// Expected output streams come from a queue-based model of the burst and round-robin rules.
module tb_chn_fifo_merge;

    localparam int N     = 2;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int BL    = 4;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            rst_all_fifo;
    logic            flush;
    logic [N*DW-1:0] chn_dataout;
    logic [N-1:0]    chn_dataout_en;
    logic            usb_ext_fifo_afull;
    logic [DW-1:0]   out_din;
    logic            out_en;
    logic [N-1:0]    chn_overflow;
    logic [N-1:0]    chn_fifo_empty;
    logic            busy;

    int passCount  = 0;
    int checkCount = 0;

    logic [15:0] outQ [$];
    logic [15:0] expQ [$];
    logic [15:0] modelQ [N][$];
    logic [N-1:0] modelOvf;
    int          modelRr;

    always #5 clk = ~clk;

    chn_fifo_merge #(
        .N_CHN     (N),
        .DATA_W    (DW),
        .FIFO_AW   (AW),
        .BURST_LEN (BL),
        .HEADER_EN (1)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .rst_all_fifo            (rst_all_fifo),
        .flush                   (flush),
        .chn_dataout             (chn_dataout),
        .chn_dataout_en          (chn_dataout_en),
        .usb_ext_fifo_afull      (usb_ext_fifo_afull),
        .out_to_usb_ext_fifo_din (out_din),
        .out_to_usb_ext_fifo_en  (out_en),
        .chn_overflow            (chn_overflow),
        .chn_fifo_empty          (chn_fifo_empty),
        .busy                    (busy)
    );

    // Capture every word written towards the USB FIFO.
    always @(negedge clk) begin
        if (out_en) begin
            outQ.push_back(out_din);
        end
    end

    // Keep a hung run from blocking the summary forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic modelClear();
        for (int c = 0; c < N; c++) begin
            modelQ[c].delete();
        end
        modelOvf = '0;
        modelRr  = 0;
    endtask

    task automatic modelWrite(input int c, input logic [15:0] d);
        if (modelQ[c].size() < DEPTH) begin
            modelQ[c].push_back(d);
        end else begin
            modelOvf[c] = 1'b1;
        end
    endtask

    task automatic modelDrain(input bit fl);
        bit found;
        do begin
            found = 1'b0;
            for (int k = 0; k < N && !found; k++) begin
                int c = (modelRr + k) % N;
                if (modelQ[c].size() >= BL || (fl && modelQ[c].size() > 0)) begin
                    int len;
                    found = 1'b1;
                    len   = (modelQ[c].size() >= BL) ? BL : modelQ[c].size();
                    expQ.push_back(16'hC500 | 16'(c));
                    for (int j = 0; j < len; j++) begin
                        expQ.push_back(modelQ[c].pop_front());
                    end
                    modelRr = (c + 1) % N;
                end
            end
        end while (found);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            for (int c = 0; c < N; c++) begin
                bit          w;
                logic [15:0] d;
                w = 1'($urandom_range(0, 1));
                d = 16'($urandom);
                chn_dataout[c*DW +: DW] = d;
                chn_dataout_en[c]       = w;
                if (w) begin
                    modelWrite(c, d);
                end
            end
            tick();
        end
        chn_dataout_en = '0;
    endtask

    task automatic compareStreams(input string tag);
        int n;
        checkOutput({tag, " count"}, 32'(outQ.size()), 32'(expQ.size()));
        n = (outQ.size() < expQ.size()) ? outQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s word%0d", tag, i), 32'(outQ[i]), 32'(expQ[i]));
        end
    endtask

    task automatic runDrain(input bit fl, input string tag);
        outQ.delete();
        expQ.delete();
        modelDrain(fl);
        flush = fl;
        for (int k = 0; k < 2000 && outQ.size() < expQ.size(); k++) begin
            usb_ext_fifo_afull = 1'($urandom_range(0, 1));
            tick();
        end
        usb_ext_fifo_afull = 1'b0;
        repeat (12) tick();
        flush = 1'b0;
        compareStreams(tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulseSoftClear();
        rst_all_fifo = 1'b1;
        tick();
        rst_all_fifo = 1'b0;
        modelClear();
    endtask

    initial begin
        int lat;
        int seen;
        int enCount;

        reset_n            = 1'b0;
        rst_all_fifo       = 1'b0;
        flush              = 1'b0;
        chn_dataout        = '0;
        chn_dataout_en     = '0;
        usb_ext_fifo_afull = 1'b0;
        modelClear();
        repeat (3) tick();
        checkOutput("reset en", 32'(out_en), 32'd0);
        checkOutput("reset din", 32'(out_din), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset empty", 32'(chn_fifo_empty), 32'h3);
        checkOutput("reset ovf", 32'(chn_overflow), 32'd0);
        reset_n = 1'b1;
        tick();

        $display("[TB] single burst on ch1");
        outQ.delete();
        for (int w = 1; w <= 4; w++) begin
            chn_dataout    = {16'(w), 16'h0000};
            chn_dataout_en = 2'b10;
            tick();
        end
        chn_dataout_en = '0;
        lat = 1;
        while (!out_en && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("first en latency", 32'(lat), 32'd3);
        checkOutput("first word header", 32'(out_din), 32'hC501);
        repeat (10) tick();
        expQ.delete();
        expQ = '{16'hC501, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        compareStreams("ch1 burst");
        checkOutput("ch1 burst busy", 32'(busy), 32'd0);
        checkOutput("ch1 burst empty", 32'(chn_fifo_empty), 32'h3);

        $display("[TB] soft clear mid burst");
        outQ.delete();
        for (int w = 0; w < 4; w++) begin
            chn_dataout    = {16'h0000, 16'(16'h0010 + w)};
            chn_dataout_en = 2'b01;
            tick();
        end
        chn_dataout_en = '0;
        seen = 0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            tick();
            if (out_en) begin
                seen++;
            end
        end
        checkOutput("pre-clear words seen", 32'(seen), 32'd3);
        pulseSoftClear();
        checkOutput("clear en", 32'(out_en), 32'd0);
        checkOutput("clear empty", 32'(chn_fifo_empty), 32'h3);
        checkOutput("clear busy", 32'(busy), 32'd0);
        enCount = 0;
        repeat (8) begin
            tick();
            if (out_en) begin
                enCount++;
            end
        end
        checkOutput("post-clear en count", 32'(enCount), 32'd0);
        expQ.delete();
        expQ = '{16'hC500, 16'h0010, 16'h0011};
        compareStreams("pre-clear stream");

        $display("[TB] overflow on ch0");
        usb_ext_fifo_afull = 1'b1;
        for (int w = 0; w < DEPTH + 1; w++) begin
            chn_dataout    = {16'h0000, 16'(16'h0100 + w)};
            chn_dataout_en = 2'b01;
            tick();
        end
        chn_dataout_en = '0;
        checkOutput("ovf set", 32'(chn_overflow), 32'h1);
        checkOutput("ovf empty", 32'(chn_fifo_empty), 32'h2);
        pulseSoftClear();
        checkOutput("ovf cleared", 32'(chn_overflow), 32'd0);
        checkOutput("ovf clear empty", 32'(chn_fifo_empty), 32'h3);
        usb_ext_fifo_afull = 1'b0;
        tick();

        $display("[TB] randomized rounds");
        for (int r = 0; r < 8; r++) begin
            usb_ext_fifo_afull = 1'b1;
            applyStimulus($urandom_range(4, 24));
            checkOutput($sformatf("r%0d ovf", r), 32'(chn_overflow), 32'(modelOvf));
            checkOutput($sformatf("r%0d empty", r), 32'(chn_fifo_empty),
                        32'({modelQ[1].size() == 0, modelQ[0].size() == 0}));
            runDrain(1'b0, $sformatf("r%0d drain", r));
            runDrain(1'b1, $sformatf("r%0d flush", r));
            checkOutput($sformatf("r%0d final empty", r), 32'(chn_fifo_empty), 32'h3);
            if (r % 2 == 1) begin
                pulseSoftClear();
                checkOutput($sformatf("r%0d ovf after clear", r), 32'(chn_overflow), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
